uart_tx: RTL and testbench

- 8-bit asynchronous serial transmitter driving the board USB-UART line (UART_RXD_OUT on Nexys A7-100T).
- Hardware counterpart of the bench's text messaging: on-chip logic streams status/debug bytes to a host terminal.
- Accepts bytes over a valid/ready handshake and serialises each as start, 8 data bits LSB first, optional parity, then stop bit(s).

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_bit_timer.sv | 38 +++
 rtl/uart_tx.sv | 145 ++++++++++++++
 tb/tb_uart_tx.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, parity mode
// constants and the bit-period helper used by both uart_tx and uart_rx.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Clock cycles per bit, rounded to the nearest whole cycle.
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable down-counter used for bit spacing.
//   CLK100MHZ   clock
//   CPU_RESETN  synchronous active-low reset
//   load        restart the count from load_val
//   load_val    cycles to wait minus one
//   done        one-cycle pulse when the loaded count reaches zero
module uart_bit_timer #(
  parameter int WIDTH = 10
) (
  input  logic             CLK100MHZ,
  input  logic             CPU_RESETN,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             done
);

  logic [WIDTH-1:0] r_count;
  logic             r_active;

  // r_active makes done a single pulse: once zero is reached the timer
  // goes quiet until it is reloaded.
  assign done = r_active && (r_count == '0);

  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      r_count  <= '0;
      r_active <= 1'b0;
    end else if (load) begin
      r_count  <= load_val;
      r_active <= 1'b1;
    end else if (r_count == '0) begin
      r_active <= 1'b0;
    end else begin
      r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8-bit UART transmitter: start bit, 8 data bits LSB first, optional
// parity, 1 or 2 stop bits. All outputs are registered.
//   CLK100MHZ   system clock
//   CPU_RESETN  synchronous active-low reset
//   tx_data     byte to send, sampled on accept
//   tx_valid    byte offered
//   tx_ready    block can accept a byte (high only in IDLE)
//   tx_busy     frame in progress (inverse of tx_ready)
//   uart_txd    serial line, idle high
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD        = 115200,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic       CLK100MHZ,
  input  logic       CPU_RESETN,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       uart_txd
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD);
  localparam int STOP_CLKS    = STOP_BITS * CLKS_PER_BIT;
  localparam int CW           = (STOP_CLKS > 1) ? $clog2(STOP_CLKS) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_CLKS - 1);

  uart_tx_state_e r_state, w_state;
  logic [7:0]     r_shift, w_shift;
  logic [2:0]     r_bit_idx, w_bit_idx;
  logic           r_par, w_par;
  logic           r_txd, w_txd;
  logic           r_ready, r_busy;
  logic           w_load;
  logic [CW-1:0]  w_load_val;
  logic           w_done;

  uart_bit_timer #(.WIDTH(CW)) u_timer (
    .CLK100MHZ  (CLK100MHZ),
    .CPU_RESETN (CPU_RESETN),
    .load       (w_load),
    .load_val   (w_load_val),
    .done       (w_done)
  );

  // Next-state logic also computes the next line level so uart_txd is a
  // flop that changes on the same edge as the state.
  always_comb begin
    w_state    = r_state;
    w_shift    = r_shift;
    w_bit_idx  = r_bit_idx;
    w_par      = r_par;
    w_txd      = r_txd;
    w_load     = 1'b0;
    w_load_val = BIT_LAST;
    unique case (r_state)
      IDLE: begin
        w_txd = 1'b1;
        if (tx_valid && r_ready) begin
          w_state   = START;
          w_shift   = tx_data;
          w_par     = (PARITY == PAR_ODD) ? ~^tx_data : ^tx_data;
          w_bit_idx = '0;
          w_txd     = 1'b0;
          w_load    = 1'b1;
        end
      end
      START: begin
        if (w_done) begin
          w_state   = DATA;
          w_bit_idx = '0;
          w_txd     = r_shift[0];
          w_load    = 1'b1;
        end
      end
      DATA: begin
        if (w_done) begin
          w_load = 1'b1;
          if (r_bit_idx == 3'd7) begin
            if (PARITY != PAR_NONE) begin
              w_state = uart_pkg::PARITY;
              w_txd   = r_par;
            end else begin
              w_state    = STOP;
              w_txd      = 1'b1;
              w_load_val = STOP_LAST;
            end
          end else begin
            w_shift   = r_shift >> 1;
            w_bit_idx = r_bit_idx + 3'd1;
            w_txd     = w_shift[0];
          end
        end
      end
      uart_pkg::PARITY: begin
        if (w_done) begin
          w_state    = STOP;
          w_txd      = 1'b1;
          w_load     = 1'b1;
          w_load_val = STOP_LAST;
        end
      end
      STOP: begin
        if (w_done) begin
          w_state = IDLE;
          w_txd   = 1'b1;
        end
      end
      default: begin
        w_state = IDLE;
        w_txd   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_par     <= 1'b0;
      r_txd     <= 1'b1;
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_shift   <= w_shift;
      r_bit_idx <= w_bit_idx;
      r_par     <= w_par;
      r_txd     <= w_txd;
      r_ready   <= (w_state == IDLE);
      r_busy    <= (w_state != IDLE);
    end
  end

  assign tx_ready = r_ready;
  assign tx_busy  = r_busy;
  assign uart_txd = r_txd;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx. Three instances share one clock:
//   d0 defaults (8N1, 868 clocks/bit), d1 even parity + 2 stop bits,
//   d2 odd parity at 8 clocks/bit for randomized traffic.
// Expected frames are built as bit lists from byte, parity mode and
// stop count, then compared with the line cycle by cycle.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst_n [3];
  logic       valid [3];
  logic [7:0] data  [3];
  logic       ready [3];
  logic       busy  [3];
  logic       txd   [3];

  int checks = 0;
  int errors = 0;
  int n_bit [3];
  int par_m [3];
  int stb   [3];

  always #5 clk = ~clk;

  uart_tx u0 (
    .CLK100MHZ(clk), .CPU_RESETN(rst_n[0]), .tx_data(data[0]), .tx_valid(valid[0]),
    .tx_ready(ready[0]), .tx_busy(busy[0]), .uart_txd(txd[0])
  );

  uart_tx #(.PARITY(2), .STOP_BITS(2)) u1 (
    .CLK100MHZ(clk), .CPU_RESETN(rst_n[1]), .tx_data(data[1]), .tx_valid(valid[1]),
    .tx_ready(ready[1]), .tx_busy(busy[1]), .uart_txd(txd[1])
  );

  uart_tx #(.CLK_FREQ_HZ(1_000_000), .BAUD(125_000), .PARITY(1), .STOP_BITS(1)) u2 (
    .CLK100MHZ(clk), .CPU_RESETN(rst_n[2]), .tx_data(data[2]), .tx_valid(valid[2]),
    .tx_ready(ready[2]), .tx_busy(busy[2]), .uart_txd(txd[2])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int bit_clocks(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

  // Offer a byte, wait (bounded) for ready, return just after the accept edge.
  task automatic offer(input int d, input logic [7:0] b);
    int w;
    data[d]  = b;
    valid[d] = 1'b1;
    w = 0;
    @(negedge clk);
    while (ready[d] !== 1'b1 && w < 30000) begin
      @(negedge clk);
      w++;
    end
    chk("accept_wait", ready[d], 1'b1);
    @(posedge clk);
    #1;
  endtask

  // Reference frame: start 0, data LSB first, parity, stop 1s; each bit
  // must hold for exactly n clocks. Mid-bit samples give the decoded byte.
  task automatic frame(input int d, input logic [7:0] b, input string tag,
                       output logic [7:0] got);
    logic bits[$];
    int   n;
    int   good;
    int   busy_cnt;
    int   rdy_lo;
    n = n_bit[d];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(b[i]);
    if (par_m[d] == 1) bits.push_back(($countones(b) % 2) == 0);
    if (par_m[d] == 2) bits.push_back(($countones(b) % 2) == 1);
    for (int i = 0; i < stb[d]; i++) bits.push_back(1'b1);
    got      = '0;
    busy_cnt = 0;
    rdy_lo   = 0;
    for (int k = 0; k < bits.size(); k++) begin
      good = 0;
      for (int c = 0; c < n; c++) begin
        @(negedge clk);
        if (txd[d] === bits[k]) good++;
        if (busy[d] === 1'b1) busy_cnt++;
        if (ready[d] === 1'b0) rdy_lo++;
        if (c == n / 2 && k >= 1 && k <= 8) got[k-1] = txd[d];
      end
      chk($sformatf("%s bit%0d", tag, k), good, n);
    end
    chk({tag, " busy_len"}, busy_cnt, bits.size() * n);
    chk({tag, " ready_lo_len"}, rdy_lo, bits.size() * n);
  endtask

  initial begin
    #1ms;
    errors++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] got, got2, b;
    int cnt;
    n_bit[0] = bit_clocks(100_000_000, 115200); par_m[0] = 0; stb[0] = 1;
    n_bit[1] = bit_clocks(100_000_000, 115200); par_m[1] = 2; stb[1] = 2;
    n_bit[2] = bit_clocks(1_000_000, 125_000);  par_m[2] = 1; stb[2] = 1;
    for (int i = 0; i < 3; i++) begin
      rst_n[i] = 1'b0;
      valid[i] = 1'b0;
      data[i]  = '0;
    end

    // Reset hold with a byte offered: nothing may start.
    valid[0] = 1'b1;
    data[0]  = 8'h3C;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_txd", txd[0], 1'b1);
      chk("rst_ready", ready[0], 1'b1);
      chk("rst_busy", busy[0], 1'b0);
    end
    @(posedge clk);
    #1;
    valid[0] = 1'b0;
    for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (txd[0] === 1'b1 && ready[0] === 1'b1) cnt++;
    end
    chk("post_rst_idle", cnt, 4);

    // Single byte 0x55.
    offer(0, 8'h55);
    valid[0] = 1'b0;
    frame(0, 8'h55, "b55", got);
    chk("b55 decode", got, 8'h55);
    @(negedge clk);
    chk("b55 ready_back", ready[0], 1'b1);

    // Back-to-back with valid held: 1-clock idle gap, receiver sees "A\n".
    offer(0, 8'h41);
    data[0] = 8'h0A;
    frame(0, 8'h41, "b2b_A", got);
    @(negedge clk);
    chk("b2b gap_txd", txd[0], 1'b1);
    chk("b2b gap_ready", ready[0], 1'b1);
    frame(0, 8'h0A, "b2b_LF", got2);
    valid[0] = 1'b0;
    chk("b2b decode_A", got, 8'h41);
    chk("b2b decode_LF", got2, 8'h0A);

    // Offer 0xFF mid-frame of 0x00: ignored, no queued frame afterwards.
    @(negedge clk);
    offer(0, 8'h00);
    valid[0] = 1'b0;
    fork
      frame(0, 8'h00, "ign", got);
      begin
        repeat (2000) @(posedge clk);
        #1;
        data[0]  = 8'hFF;
        valid[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        valid[0] = 1'b0;
        data[0]  = 8'hC3;
      end
    join
    chk("ign decode", got, 8'h00);
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (txd[0] === 1'b1 && ready[0] === 1'b1) cnt++;
    end
    chk("ign no_second_frame", cnt, 20);

    // Reset during data bit 3 of 0x00, then 0xA5 with full timing.
    offer(0, 8'h00);
    valid[0] = 1'b0;
    repeat (4 * n_bit[0] + n_bit[0] / 2) @(negedge clk);
    chk("midrst pre_txd", txd[0], 1'b0);
    rst_n[0] = 1'b0;
    @(negedge clk);
    chk("midrst txd", txd[0], 1'b1);
    chk("midrst ready", ready[0], 1'b1);
    chk("midrst busy", busy[0], 1'b0);
    rst_n[0] = 1'b1;
    offer(0, 8'hA5);
    valid[0] = 1'b0;
    frame(0, 8'hA5, "a5", got);
    chk("a5 decode", got, 8'hA5);
    @(negedge clk);
    chk("a5 ready_back", ready[0], 1'b1);

    // Even parity, two stop bits: 0x07 -> parity 1, 12-bit frame.
    offer(1, 8'h07);
    valid[1] = 1'b0;
    frame(1, 8'h07, "pev", got);
    chk("pev decode", got, 8'h07);

    // Odd parity: 0x07 -> parity 0, then randomized bytes with busy pokes.
    offer(2, 8'h07);
    valid[2] = 1'b0;
    frame(2, 8'h07, "pod", got);
    chk("pod decode", got, 8'h07);
    for (int i = 0; i < 24; i++) begin
      b = 8'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      offer(2, b);
      valid[2] = 1'b0;
      data[2]  = 8'($urandom);
      fork
        frame(2, b, $sformatf("rnd%0d", i), got);
        begin
          repeat ($urandom_range(1, 4 * n_bit[2])) @(posedge clk);
          #1;
          valid[2] = 1'b1;
          data[2]  = 8'($urandom);
          @(posedge clk);
          #1;
          valid[2] = 1'b0;
        end
      join
      chk($sformatf("rnd%0d decode", i), got, b);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
